// File: rtl/imem_boot_loader.sv
// Boot loader: receives a little-endian framed image (word count, then words) over a byte
// stream and writes it into instruction RAM in PC form, holding the CPU until the load completes.
module imem_boot_loader #(
  parameter logic [31:0] PC_INITIAL     = 32'hbfc00000,
  parameter int unsigned MAX_WORDS      = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        ram_we,
  output logic [31:0] ram_pc,
  output logic [31:0] ram_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [16:0] words_loaded
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WL_W   = 17;
  localparam int unsigned TMO_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic               rx_ready_d, ram_we_d, cpu_hold_d, done_d, error_d;
  logic [WORD_W-1:0]  ram_pc_d, ram_wdata_d;
  logic [WL_W-1:0]    words_loaded_d;

  logic               accept;
  logic               tmo_hit;
  logic               last_byte;
  logic [WORD_W-1:0]  count_next;
  logic [WORD_W-1:0]  word_next;

  // Bytes shift in from the top so the first byte ends up in bits [7:0].
  assign accept     = rx_valid & rx_ready;
  assign last_byte  = (byte_cnt_q == 2'd3);
  assign count_next = {rx_data, count_q[WORD_W-1:8]};
  assign word_next  = {rx_data, word_q[WORD_W-1:8]};
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) &&
                      ((tmo_cnt_q + TMO_W'(1)) == TMO_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    word_d         = word_q;
    byte_cnt_d     = byte_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    rx_ready_d     = rx_ready;
    ram_we_d       = 1'b0;
    ram_pc_d       = ram_pc;
    ram_wdata_d    = ram_wdata;
    cpu_hold_d     = cpu_hold;
    done_d         = done;
    error_d        = error;
    words_loaded_d = words_loaded;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d        = S_HDR;
          rx_ready_d     = 1'b1;
          cpu_hold_d     = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          ram_pc_d       = PC_INITIAL;
          byte_cnt_d     = '0;
          tmo_cnt_d      = '0;
        end
      end

      S_HDR: begin
        if (accept) begin
          count_d    = count_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmo_cnt_d  = '0;
          if (last_byte) begin
            if (count_next == '0) begin
              state_d    = S_DONE;
              rx_ready_d = 1'b0;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
            end else if (count_next > WORD_W'(MAX_WORDS)) begin
              state_d    = S_ERR;
              rx_ready_d = 1'b0;
              error_d    = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end else if (tmo_hit) begin
          state_d    = S_ERR;
          rx_ready_d = 1'b0;
          error_d    = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d     = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmo_cnt_d  = '0;
          if (last_byte) begin
            state_d     = S_WRITE;
            rx_ready_d  = 1'b0;
            ram_we_d    = 1'b1;
            ram_pc_d    = PC_INITIAL + WORD_W'({words_loaded, 2'b00});
            ram_wdata_d = word_next;
          end
        end else if (tmo_hit) begin
          state_d    = S_ERR;
          rx_ready_d = 1'b0;
          error_d    = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      S_WRITE: begin
        words_loaded_d = words_loaded + WL_W'(1);
        tmo_cnt_d      = '0;
        byte_cnt_d     = '0;
        if ((WORD_W'(words_loaded) + WORD_W'(1)) == count_q) begin
          state_d    = S_DONE;
          rx_ready_d = 1'b0;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          state_d    = S_DATA;
          rx_ready_d = 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        rx_ready_d = 1'b0;
        cpu_hold_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      rx_ready     <= 1'b0;
      ram_we       <= 1'b0;
      ram_pc       <= PC_INITIAL;
      ram_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rx_ready     <= rx_ready_d;
      ram_we       <= ram_we_d;
      ram_pc       <= ram_pc_d;
      ram_wdata    <= ram_wdata_d;
      cpu_hold     <= cpu_hold_d;
      done         <= done_d;
      error        <= error_d;
      words_loaded <= words_loaded_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framed loads, header limits, timeout, mid-load reset, reload.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        ram_we;
  logic [31:0] ram_pc;
  logic [31:0] ram_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [16:0] words_loaded;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_pc[$];
  logic [31:0] wr_data[$];
  int          we_run  = 0;
  logic        we_long = 1'b0;

  imem_boot_loader #(
    .PC_INITIAL    (32'hbfc00000),
    .MAX_WORDS     (65536),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .ram_we      (ram_we),
    .ram_pc      (ram_pc),
    .ram_wdata   (ram_wdata),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM-side observer: logs every write strobe and flags strobes wider than one cycle.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_pc.push_back(ram_pc);
      wr_data.push_back(ram_wdata);
      we_run = we_run + 1;
      if (we_run > 1) we_long = 1'b1;
    end else begin
      we_run = 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL byte_accept: rx_ready=%0b never rose for byte %02h", rx_ready, b);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rst_rx_ready: got %0b exp 0", rx_ready); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we: got %0b exp 0", ram_we); end
    total++; if (ram_pc !== 32'hbfc00000) begin bad++; $display("FAIL rst_ram_pc: got %08h exp bfc00000", ram_pc); end
    total++; if (ram_wdata !== 32'h0) begin bad++; $display("FAIL rst_ram_wdata: got %08h exp 0", ram_wdata); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold: got %0b exp 1", cpu_hold); end
    total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_done_err: got %0b/%0b exp 0/0", done, error); end
    total++; if (words_loaded !== 17'd0) begin bad++; $display("FAIL rst_words: got %0d exp 0", words_loaded); end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // rx_valid in IDLE must not be consumed
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin bad++; $display("FAIL idle_ignore: rx_ready=%0b cpu_hold=%0b exp 0/1", rx_ready, cpu_hold); end
    rx_valid = 1'b0;
  endtask

  task automatic test_two_words();
    wr_pc.delete(); wr_data.delete();
    pulse_start();
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL t1_hdr_ready: got %0b exp 1", rx_ready); end
    send_word(32'h00000002, 0);
    send_word(32'h12345678, 0);
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL t1_we0: got %0b exp 1", ram_we); end
    total++; if (ram_pc !== 32'hbfc00000) begin bad++; $display("FAIL t1_pc0: got %08h exp bfc00000", ram_pc); end
    total++; if (ram_wdata !== 32'h12345678) begin bad++; $display("FAIL t1_data0: got %08h exp 12345678", ram_wdata); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL t1_ready_drop: got %0b exp 0", rx_ready); end
    @(posedge clk); #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL t1_we0_low: got %0b exp 0", ram_we); end
    total++; if (words_loaded !== 17'd1) begin bad++; $display("FAIL t1_words1: got %0d exp 1", words_loaded); end
    total++; if (rx_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL t1_mid: rx_ready=%0b done=%0b exp 1/0", rx_ready, done); end
    send_word(32'hdeadbeef, 0);
    total++; if (ram_we !== 1'b1 || ram_pc !== 32'hbfc00004 || ram_wdata !== 32'hdeadbeef) begin
      bad++; $display("FAIL t1_wr1: we=%0b pc=%08h data=%08h exp 1/bfc00004/deadbeef", ram_we, ram_pc, ram_wdata);
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 17'd2 || rx_ready !== 1'b0) begin
      bad++; $display("FAIL t1_done: done=%0b hold=%0b words=%0d ready=%0b exp 1/0/2/0", done, cpu_hold, words_loaded, rx_ready);
    end
    total++; if (wr_pc.size() !== 2 || we_long !== 1'b0) begin bad++; $display("FAIL t1_wr_count: got %0d long=%0b exp 2/0", wr_pc.size(), we_long); end
  endtask

  task automatic test_zero_count();
    wr_pc.delete(); wr_data.delete();
    pulse_start();
    total++; if (done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 17'd0 || ram_pc !== 32'hbfc00000) begin
      bad++; $display("FAIL t2_restart: done=%0b hold=%0b words=%0d pc=%08h exp 0/1/0/bfc00000", done, cpu_hold, words_loaded, ram_pc);
    end
    send_word(32'h00000000, 0);
    total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || rx_ready !== 1'b0) begin
      bad++; $display("FAIL t2_done: done=%0b hold=%0b ready=%0b exp 1/0/0", done, cpu_hold, rx_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (wr_pc.size() !== 0) begin bad++; $display("FAIL t2_no_write: got %0d writes exp 0", wr_pc.size()); end
  endtask

  task automatic test_bad_count();
    wr_pc.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h00010001, 0);
    total++; if (error !== 1'b1 || cpu_hold !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL t3_err: err=%0b hold=%0b ready=%0b done=%0b exp 1/1/0/0", error, cpu_hold, rx_ready, done);
    end
    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (6) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    total++; if (wr_pc.size() !== 0 || rx_ready !== 1'b0 || error !== 1'b1) begin
      bad++; $display("FAIL t3_stay: writes=%0d ready=%0b err=%0b exp 0/0/1", wr_pc.size(), rx_ready, error);
    end
  endtask

  task automatic test_max_count_and_reset();
    wr_pc.delete(); wr_data.delete();
    pulse_start();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL t5_err_clear: got %0b exp 0", error); end
    send_word(32'h00010000, 0);
    total++; if (error !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL t5_max_ok: err=%0b ready=%0b exp 0/1", error, rx_ready); end
    send_word(32'ha5a5a5a5, 0);
    @(posedge clk); #1;
    total++; if (words_loaded !== 17'd1 || wr_pc.size() !== 1) begin bad++; $display("FAIL t5_word0: words=%0d writes=%0d exp 1/1", words_loaded, wr_pc.size()); end
    send_byte(8'h01);
    send_byte(8'h02);
    wr_pc.delete(); wr_data.delete();
    rst_n = 1'b0;
    #1;
    total++; if (ram_we !== 1'b0 || ram_pc !== 32'hbfc00000 || ram_wdata !== 32'h0 || rx_ready !== 1'b0) begin
      bad++; $display("FAIL t5_rst_bus: we=%0b pc=%08h data=%08h ready=%0b exp 0/bfc00000/0/0", ram_we, ram_pc, ram_wdata, rx_ready);
    end
    total++; if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 17'd0) begin
      bad++; $display("FAIL t5_rst_flags: hold=%0b done=%0b err=%0b words=%0d exp 1/0/0/0", cpu_hold, done, error, words_loaded);
    end
    rx_valid = 1'b1; rx_data = 8'h03;
    repeat (3) @(posedge clk);
    #3;
    rx_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    send_word(32'h00000001, 0);
    send_word(32'h11223344, 0);
    @(posedge clk); #1;
    total++; if (wr_pc.size() !== 1) begin bad++; $display("FAIL t5_reload_cnt: got %0d writes exp 1", wr_pc.size()); end
    else begin
      total++; if (wr_pc[0] !== 32'hbfc00000 || wr_data[0] !== 32'h11223344) begin
        bad++; $display("FAIL t5_reload_wr: pc=%08h data=%08h exp bfc00000/11223344", wr_pc[0], wr_data[0]);
      end
    end
    total++; if (done !== 1'b1 || words_loaded !== 17'd1) begin bad++; $display("FAIL t5_reload_done: done=%0b words=%0d exp 1/1", done, words_loaded); end
  endtask

  task automatic test_reload_from_done();
    wr_pc.delete(); wr_data.delete();
    pulse_start();
    total++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin bad++; $display("FAIL t6_restart: done=%0b hold=%0b exp 0/1", done, cpu_hold); end
    send_byte(8'h01);
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h0D);
    send_byte(8'hF0);
    pulse_start();
    total++; if (rx_ready !== 1'b1 || words_loaded !== 17'd0 || done !== 1'b0) begin
      bad++; $display("FAIL t6_start_ign: ready=%0b words=%0d done=%0b exp 1/0/0", rx_ready, words_loaded, done);
    end
    send_byte(8'hFE);
    send_byte(8'hCA);
    total++; if (ram_we !== 1'b1 || ram_pc !== 32'hbfc00000 || ram_wdata !== 32'hcafef00d) begin
      bad++; $display("FAIL t6_wr: we=%0b pc=%08h data=%08h exp 1/bfc00000/cafef00d", ram_we, ram_pc, ram_wdata);
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 17'd1 || wr_pc.size() !== 1) begin
      bad++; $display("FAIL t6_done: done=%0b hold=%0b words=%0d writes=%0d exp 1/0/1/1", done, cpu_hold, words_loaded, wr_pc.size());
    end
  endtask

  task automatic test_timeout();
    wr_pc.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h00000001, 15);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL t4_hdr_gap15: err=%0b exp 0", error); end
    send_word(32'h0badf00d, 15);
    @(posedge clk); #1;
    total++; if (done !== 1'b1 || error !== 1'b0 || wr_pc.size() !== 1) begin
      bad++; $display("FAIL t4_gap15_done: done=%0b err=%0b writes=%0d exp 1/0/1", done, error, wr_pc.size());
    end
    else begin
      total++; if (wr_data[0] !== 32'h0badf00d || wr_pc[0] !== 32'hbfc00000) begin
        bad++; $display("FAIL t4_gap15_wr: pc=%08h data=%08h exp bfc00000/0badf00d", wr_pc[0], wr_data[0]);
      end
    end
    wr_pc.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h00000001, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (15) @(posedge clk);
    #1;
    total++; if (error !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL t4_edge15: err=%0b ready=%0b exp 0/1", error, rx_ready); end
    @(posedge clk); #1;
    total++; if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      bad++; $display("FAIL t4_timeout: err=%0b ready=%0b hold=%0b exp 1/0/1", error, rx_ready, cpu_hold);
    end
    rx_valid = 1'b1; rx_data = 8'h33;
    repeat (4) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    total++; if (wr_pc.size() !== 0 || ram_we !== 1'b0) begin bad++; $display("FAIL t4_no_partial: writes=%0d we=%0b exp 0/0", wr_pc.size(), ram_we); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_bad_count();
    test_max_count_and_reset();
    test_reload_from_done();
    test_timeout();
    total++; if (we_long !== 1'b0) begin bad++; $display("FAIL we_width: long strobe seen=%0b exp 0", we_long); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
